display_scan_ctrl: RTL and testbench

// - Time-multiplexes NUM_DIGITS seven-segment digits over one shared channel decoder (3-bit symbol -> 8-bit active-low segment pattern).
// - Each frame visits every digit in turn: blanking gap, then dwell.
// - Drives the decoder's symbol input, the active-low anodes and a frame tick.
// - Symbols are double-buffered so a frame never tears. Sits between game/channel logic and the display pins.

---
 rtl/disp_pkg.sv | 18 +
 rtl/scan_timer.sv | 34 +++
 rtl/display_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and scan state encoding for the seven-segment scan controller.
package disp_pkg;

    localparam logic [2:0] SYM_ONE       = 3'b000;
    localparam logic [2:0] SYM_TWO       = 3'b001;
    localparam logic [2:0] SYM_THREE     = 3'b010;
    localparam logic [2:0] SYM_LEGAL_MAX = SYM_THREE;

    typedef logic [1:0] scan_state_t;
    localparam scan_state_t ST_IDLE  = 2'd0;
    localparam scan_state_t ST_BLANK = 2'd1;
    localparam scan_state_t ST_SHOW  = 2'd2;

    function automatic logic sym_legal(input logic [2:0] sym);
        return sym <= SYM_LEGAL_MAX;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Up-counter with terminal-count compare; restarts from zero on terminal count or clear.
module scan_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         done_o
);

    logic [W-1:0] count_q, count_d;

    assign done_o = en_i && (count_q == term_i);

    always_comb begin
        count_d = count_q;
        if (clr_i || done_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans NUM_DIGITS seven-segment digits over one shared decoder, with a blanking
// gap before every digit and double-buffered symbols committed only at frame wrap.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    load,
    input  logic [3*NUM_DIGITS-1:0] sym_in,
    input  logic [NUM_DIGITS-1:0]   valid_in,
    output logic [2:0]              seg_sym,
    output logic                    seg_blank,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_tick
);

    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    scan_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [NUM_DIGITS-1:0][2:0] act_sym_q, act_sym_d, pend_sym_q, pend_sym_d;
    logic [NUM_DIGITS-1:0] act_vld_q, act_vld_d, pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic [2:0] seg_sym_q, seg_sym_d;
    logic seg_blank_q, seg_blank_d, frame_tick_q, frame_tick_d;
    logic timer_clr, timer_en, timer_done, commit, lit_d;
    logic [TW-1:0] timer_term;

    assign timer_en   = enable && (state_q != ST_IDLE);
    assign timer_term = (state_q == ST_SHOW) ? TW'(DWELL_CYCLES - 1) : TW'(BLANK_CYCLES - 1);

    scan_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .term_i (timer_term),
        .done_o (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        timer_clr    = 1'b0;
        commit       = 1'b0;
        frame_tick_d = 1'b0;
        if (!enable) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            timer_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_BLANK;
                    idx_d     = '0;
                    timer_clr = 1'b1;
                    commit    = 1'b1;
                end
                ST_BLANK: if (timer_done) state_d = ST_SHOW;
                ST_SHOW: if (timer_done) begin
                    state_d = ST_BLANK;
                    if (idx_q == IW'(NUM_DIGITS - 1)) begin
                        idx_d        = '0;
                        commit       = 1'b1;
                        frame_tick_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Commit takes the registered pending copy; a load on the same edge lands in pending only.
    always_comb begin
        pend_sym_d = pend_sym_q;
        pend_vld_d = pend_vld_q;
        if (load) begin
            pend_sym_d = sym_in;
            pend_vld_d = valid_in;
        end
        act_sym_d = commit ? pend_sym_q : act_sym_q;
        act_vld_d = commit ? pend_vld_q : act_vld_q;
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_comb begin
        lit_d       = (state_d == ST_SHOW) && act_vld_d[idx_d] && sym_legal(act_sym_d[idx_d]);
        an_n_d      = lit_d ? ~(NUM_DIGITS'(1) << idx_d) : '1;
        seg_blank_d = !lit_d;
        seg_sym_d   = (state_d == ST_IDLE) ? seg_sym_q : act_sym_d[idx_d];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            act_sym_q    <= {NUM_DIGITS{SYM_ONE}};
            act_vld_q    <= '0;
            pend_sym_q   <= {NUM_DIGITS{SYM_ONE}};
            pend_vld_q   <= '0;
            an_n_q       <= '1;
            seg_sym_q    <= SYM_ONE;
            seg_blank_q  <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            act_sym_q    <= act_sym_d;
            act_vld_q    <= act_vld_d;
            pend_sym_q   <= pend_sym_d;
            pend_vld_q   <= pend_vld_d;
            an_n_q       <= an_n_d;
            seg_sym_q    <= seg_sym_d;
            seg_blank_q  <= seg_blank_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an_n       = an_n_q;
    assign seg_sym    = seg_sym_q;
    assign seg_blank  = seg_blank_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with NUM_DIGITS=3, DWELL=4, BLANK=2.
module tb_display_scan_ctrl;

    localparam logic [8:0] SYM_A = 9'b010_001_000;
    localparam logic [8:0] SYM_B = 9'b010_111_000;
    localparam logic [8:0] SYM_C = 9'b000_010_001;
    localparam logic [8:0] SYM_D = 9'b001_000_010;

    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic       load;
    logic [8:0] sym_in;
    logic [2:0] valid_in;
    logic [2:0] seg_sym;
    logic       seg_blank;
    logic [2:0] an_n;
    logic       frame_tick;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic       ld;
        logic [8:0] s;
        logic [2:0] v;
        logic [2:0] an;
        logic [2:0] ss;
        logic       bl;
        logic       tk;
        int         n;
    } vec_t;

    vec_t tbl[20];

    display_scan_ctrl #(
        .NUM_DIGITS  (3),
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .load      (load),
        .sym_in    (sym_in),
        .valid_in  (valid_in),
        .seg_sym   (seg_sym),
        .seg_blank (seg_blank),
        .an_n      (an_n),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic en, input logic ld, input logic [8:0] s,
                                input logic [2:0] v, input logic [2:0] an, input logic [2:0] ss,
                                input logic bl, input logic tk, input int n);
        vec_t r;
        r.en = en; r.ld = ld; r.s = s; r.v = v;
        r.an = an; r.ss = ss; r.bl = bl; r.tk = tk; r.n = n;
        return r;
    endfunction

    // Drives n cycles (load only on the first), pushing the expected output of each edge.
    task automatic step(input string name, input logic en, input logic ld, input logic [8:0] s,
                        input logic [2:0] v, input logic [2:0] an, input logic [2:0] ss,
                        input logic bl, input logic tk, input int n);
        logic [7:0] got;
        logic [7:0] exp;
        for (int i = 0; i < n; i++) begin
            enable   = en;
            load     = (i == 0) ? ld : 1'b0;
            sym_in   = s;
            valid_in = v;
            exp_q.push_back({an, ss, bl, tk});
            @(posedge clk);
            #1;
            got = {an_n, seg_sym, seg_blank, frame_tick};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got an_n=%b seg_sym=%b seg_blank=%b frame_tick=%b, expected an_n=%b seg_sym=%b seg_blank=%b frame_tick=%b",
                         name, i, got[7:5], got[4:2], got[1], got[0], exp[7:5], exp[4:2], exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        resetn = 1'b0; enable = 1'b1; load = 1'b0; sym_in = '0; valid_in = '0;

        // Frame 1 with A, load B mid frame 2, frame 3 shows B (illegal d1, invalid d2).
        tbl[0]  = mk(0, 1, SYM_A, 3'b111, 3'b111, 3'b000, 1, 0, 1);
        tbl[1]  = mk(1, 0, SYM_A, 3'b111, 3'b111, 3'b000, 1, 0, 2);
        tbl[2]  = mk(1, 0, SYM_A, 3'b111, 3'b110, 3'b000, 0, 0, 4);
        tbl[3]  = mk(1, 0, SYM_A, 3'b111, 3'b111, 3'b001, 1, 0, 2);
        tbl[4]  = mk(1, 0, SYM_A, 3'b111, 3'b101, 3'b001, 0, 0, 4);
        tbl[5]  = mk(1, 0, SYM_A, 3'b111, 3'b111, 3'b010, 1, 0, 2);
        tbl[6]  = mk(1, 0, SYM_A, 3'b111, 3'b011, 3'b010, 0, 0, 4);
        tbl[7]  = mk(1, 0, SYM_A, 3'b111, 3'b111, 3'b000, 1, 1, 1);
        tbl[8]  = mk(1, 1, SYM_B, 3'b011, 3'b111, 3'b000, 1, 0, 1);
        tbl[9]  = mk(1, 0, SYM_B, 3'b011, 3'b110, 3'b000, 0, 0, 4);
        tbl[10] = mk(1, 0, SYM_B, 3'b011, 3'b111, 3'b001, 1, 0, 2);
        tbl[11] = mk(1, 0, SYM_B, 3'b011, 3'b101, 3'b001, 0, 0, 4);
        tbl[12] = mk(1, 0, SYM_B, 3'b011, 3'b111, 3'b010, 1, 0, 2);
        tbl[13] = mk(1, 0, SYM_B, 3'b011, 3'b011, 3'b010, 0, 0, 4);
        tbl[14] = mk(1, 0, SYM_B, 3'b011, 3'b111, 3'b000, 1, 1, 1);
        tbl[15] = mk(1, 0, SYM_B, 3'b011, 3'b111, 3'b000, 1, 0, 1);
        tbl[16] = mk(1, 0, SYM_B, 3'b011, 3'b110, 3'b000, 0, 0, 4);
        tbl[17] = mk(1, 0, SYM_B, 3'b011, 3'b111, 3'b111, 1, 0, 6);
        tbl[18] = mk(1, 0, SYM_B, 3'b011, 3'b111, 3'b010, 1, 0, 6);
        tbl[19] = mk(1, 0, SYM_B, 3'b011, 3'b111, 3'b000, 1, 1, 1);

        step("reset", 1, 0, '0, '0, 3'b111, 3'b000, 1, 0, 2);
        resetn = 1'b1;

        for (int r = 0; r < 20; r++) begin
            step($sformatf("table_row%0d", r), tbl[r].en, tbl[r].ld, tbl[r].s, tbl[r].v,
                 tbl[r].an, tbl[r].ss, tbl[r].bl, tbl[r].tk, tbl[r].n);
        end

        // Frame 4 (B active): load C mid-SHOW of digit1, load D sampled on the wrap edge.
        step("f4_d0_blank", 1, 0, SYM_C, 3'b111, 3'b111, 3'b000, 1, 0, 1);
        step("f4_d0_show",  1, 0, SYM_C, 3'b111, 3'b110, 3'b000, 0, 0, 4);
        step("f4_d1_blank", 1, 0, SYM_C, 3'b111, 3'b111, 3'b111, 1, 0, 3);
        step("f4_d1_load",  1, 1, SYM_C, 3'b111, 3'b111, 3'b111, 1, 0, 3);
        step("f4_d2",       1, 0, SYM_C, 3'b111, 3'b111, 3'b010, 1, 0, 6);
        step("f4_wrap_ldD", 1, 1, SYM_D, 3'b111, 3'b111, 3'b001, 1, 1, 1);
        // Frame 5 shows C; D appears only after the next wrap.
        step("f5_d0_blank", 1, 0, SYM_D, 3'b111, 3'b111, 3'b001, 1, 0, 1);
        step("f5_d0_show",  1, 0, SYM_D, 3'b111, 3'b110, 3'b001, 0, 0, 4);
        step("f5_d1_blank", 1, 0, SYM_D, 3'b111, 3'b111, 3'b010, 1, 0, 2);
        step("f5_d1_show",  1, 0, SYM_D, 3'b111, 3'b101, 3'b010, 0, 0, 4);
        step("f5_d2_blank", 1, 0, SYM_D, 3'b111, 3'b111, 3'b000, 1, 0, 2);
        step("f5_d2_show",  1, 0, SYM_D, 3'b111, 3'b011, 3'b000, 0, 0, 4);
        step("f5_wrap",     1, 0, SYM_D, 3'b111, 3'b111, 3'b010, 1, 1, 1);
        // Frame 6 shows D; disable mid-SHOW of digit2.
        step("f6_d0_blank", 1, 0, SYM_D, 3'b111, 3'b111, 3'b010, 1, 0, 1);
        step("f6_d0_show",  1, 0, SYM_D, 3'b111, 3'b110, 3'b010, 0, 0, 4);
        step("f6_d1_blank", 1, 0, SYM_D, 3'b111, 3'b111, 3'b000, 1, 0, 2);
        step("f6_d1_show",  1, 0, SYM_D, 3'b111, 3'b101, 3'b000, 0, 0, 4);
        step("f6_d2_blank", 1, 0, SYM_D, 3'b111, 3'b111, 3'b001, 1, 0, 2);
        step("f6_d2_show",  1, 0, SYM_D, 3'b111, 3'b011, 3'b001, 0, 0, 2);
        step("disable",     0, 0, SYM_D, 3'b111, 3'b111, 3'b001, 1, 0, 2);
        step("reen_blank",  1, 0, SYM_D, 3'b111, 3'b111, 3'b010, 1, 0, 2);
        step("reen_d0",     1, 0, SYM_D, 3'b111, 3'b110, 3'b010, 0, 0, 4);
        step("reen_d1_blk", 1, 0, SYM_D, 3'b111, 3'b111, 3'b000, 1, 0, 2);
        step("reen_d1",     1, 0, SYM_D, 3'b111, 3'b101, 3'b000, 0, 0, 1);

        // Reset mid-SHOW: dark immediately, pending lost, dark frame until a new load.
        resetn = 1'b0;
        step("mid_reset",   1, 0, SYM_D, 3'b111, 3'b111, 3'b000, 1, 0, 1);
        resetn = 1'b1;
        step("post_rst_en", 1, 0, SYM_A, 3'b111, 3'b111, 3'b000, 1, 0, 1);
        step("dark_load",   1, 1, SYM_A, 3'b111, 3'b111, 3'b000, 1, 0, 1);
        step("dark_frame",  1, 0, SYM_A, 3'b111, 3'b111, 3'b000, 1, 0, 16);
        step("dark_wrap",   1, 0, SYM_A, 3'b111, 3'b111, 3'b000, 1, 1, 1);
        step("lit_d0_blk",  1, 0, SYM_A, 3'b111, 3'b111, 3'b000, 1, 0, 1);
        step("lit_d0",      1, 0, SYM_A, 3'b111, 3'b110, 3'b000, 0, 0, 4);
        step("lit_d1_blk",  1, 0, SYM_A, 3'b111, 3'b111, 3'b001, 1, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
